output_writeback_ctrl: RTL and testbench
========================================

// Module: output_writeback_ctrl
// PURPOSE
//  Sequences the fixed-latency output data pipeline of the convolution engine and drains it into the output buffer.
//  Grants upstream issue slots using credits, shadows pipeline occupancy with a valid shift chain, and catches tail results in a skid FIFO.
//  Drains the FIFO over a ready/valid write port with raster addresses; sits between the MAC array output and the output buffer.
// PARAMETERS
//  DataWidth  32  result word width (matches output data pipeline)
//  Stages     5   output data pipeline depth in cycles; >=1
//  FifoDepth  8   skid FIFO entries; power of two, >=2
//  OutCols    16  output frame columns
//  OutRows    16  output frame rows
//  AddrWidth  8   wr_addr width; 2**AddrWidth >= OutCols*OutRows
// PORTS
//  clk          in   1          clock, rising edge
//  aclr         in   1          reset, asynchronous, active-high; clears every register in this block
//  start        in   1          1-cycle pulse: begin a frame; ignored while busy
//  issue_req    in   1          upstream has a result to drive into the output data pipeline this cycle
//  issue_grant  out  1          combinational; result is accepted into the pipeline this cycle
//  pipe_data    in   DataWidth  output data pipeline tail (DataOut)
//  wr_valid     out  1          FIFO head valid
//  wr_ready     in   1          output buffer accepts the word
//  wr_data      out  DataWidth  FIFO head data
//  wr_addr      out  AddrWidth  linear address row*OutCols+col of the FIFO head
//  credits      out  $clog2(FifoDepth)+1  free slots: FifoDepth - fifo_count - inflight
//  busy         out  1          frame in progress
//  frame_done   out  1          1-cycle pulse, cycle after the last pixel's write handshake
// BEHAVIOUR
//  Reset values: vld chain 0, FIFO empty, issue/write counters 0, busy 0, frame_done 0, wr_valid 0, wr_addr 0, credits FifoDepth.
//  States: IDLE -> RUN on start. RUN -> IDLE on the last write pop; frame_done is registered off that transition.
//  issue_grant = (state==RUN) & issue_req & (credits!=0) & (issue_cnt < OutCols*OutRows).
//  Valid chain vld[0..Stages-1]: vld[0]<=issue_grant; vld[i+1]<=vld[i]. inflight = popcount(vld).
//  Latency: a grant in cycle t places the word at pipe_data in cycle t+Stages, where vld[Stages-1]=1 pushes it into the FIFO.
//  Pop when wr_valid & wr_ready. Push and pop in the same cycle: count unchanged, both pointers advance.
//  Push while full cannot occur, because credits reserve a slot per grant. Simulation assertion: full & push is an error.
//  The credit a pop frees is usable for a grant in the next cycle, not combinationally in the same cycle.
//  wr_addr = write counter. It increments per pop and wraps from OutCols*OutRows-1 to 0. The issue counter clears on the RUN->IDLE transition.
//  wr_valid/wr_data are FIFO outputs. They are stable while wr_valid & !wr_ready.
//  start while busy: no effect. start in the same cycle as frame_done: accepted (state already IDLE).
//  aclr mid-frame: all state cleared. In-flight words are discarded; the output data pipeline is cleared by the same aclr.
//  Counters use unsigned widths sized by $clog2; no truncation of OutCols*OutRows.
// STRUCTURE
//  Package conv_engine_pkg: FRAME_PIXELS = OutCols*OutRows, the ctrl state enum {IDLE, RUN}, and a clog2 helper if the tool lacks one.
//  Sub-module: output_skid_fifo (sync FIFO: DataWidth x FifoDepth, push/pop/full/empty/count, aclr async).
//  Top: FSM, valid chain, credit arithmetic, issue/write counters.
// TESTING
//  Reset, then start; issue_req held high and wr_ready high -> first grant in the cycle after start, first wr_valid Stages+1 cycles after the first grant.
//  Same run continued -> wr_addr 0..255 in order, frame_done exactly once, busy low in the same cycle.
//  wr_ready=0 for the whole frame, Stages=5, FifoDepth=8 -> exactly 8 grants, credits reach 0, no overflow assertion; wr_ready=1 then resumes grants.
//  Random wr_ready (50%) and random issue_req -> every pushed word written exactly once, in order, with matching data; grants total 256.
//  aclr pulsed mid-frame after 37 writes -> all outputs at reset values next cycle; a new start writes from wr_addr 0.
//  start pulsed while busy, and start coincident with frame_done -> first ignored, second begins a new frame.

Source files
------------

// File: rtl/conv_engine_pkg.sv
// conv_engine_pkg: shared frame geometry and output-control state for the convolution engine
package conv_engine_pkg;
    localparam int OUT_COLS     = 16;
    localparam int OUT_ROWS     = 16;
    localparam int FRAME_PIXELS = OUT_COLS * OUT_ROWS;
    typedef enum logic {IDLE, RUN} ctrl_state_e;
endpackage

// File: rtl/output_skid_fifo.sv
// output_skid_fifo: synchronous FIFO catching output pipeline tail results
module output_skid_fifo #(
    parameter int DataWidth = 32,
    parameter int Depth     = 8
) (
    input  logic                   clk,
    input  logic                   aclr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DataWidth-1:0]   din,
    output logic [DataWidth-1:0]   dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(Depth):0] count
);
    localparam int PtrW = $clog2(Depth);
    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] mem_d [Depth];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]        count_q, count_d;
    // Pointers wrap naturally because Depth is a power of two
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = din;
        wr_ptr_d = wr_ptr_q + PtrW'(push);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        count_d  = count_q + (PtrW+1)'(push) - (PtrW+1)'(pop);
    end
    // Storage and pointer registers, all cleared by aclr
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    assign dout  = mem_q[rd_ptr_q];
    assign full  = count_q == (PtrW+1)'(Depth);
    assign empty = count_q == '0;
    assign count = count_q;
endmodule

// File: rtl/output_writeback_ctrl.sv
// output_writeback_ctrl: credit-gated issue into the output pipeline and raster drain to the output buffer
module output_writeback_ctrl
    import conv_engine_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int Stages    = 5,
    parameter int FifoDepth = 8,
    parameter int OutCols   = OUT_COLS,
    parameter int OutRows   = OUT_ROWS,
    parameter int AddrWidth = 8
) (
    input  logic                         clk,
    input  logic                         aclr,
    input  logic                         start,
    input  logic                         issue_req,
    output logic                         issue_grant,
    input  logic [DataWidth-1:0]         pipe_data,
    output logic                         wr_valid,
    input  logic                         wr_ready,
    output logic [DataWidth-1:0]         wr_data,
    output logic [AddrWidth-1:0]         wr_addr,
    output logic [$clog2(FifoDepth):0]   credits,
    output logic                         busy,
    output logic                         frame_done
);
    localparam int frame_pix = OutCols * OutRows;
    localparam int credit_w  = $clog2(FifoDepth) + 1;
    localparam int issue_w   = $clog2(frame_pix + 1);
    ctrl_state_e          state_q, state_d;
    logic [Stages-1:0]    vld_q, vld_d;
    logic [issue_w-1:0]   issue_cnt_q, issue_cnt_d;
    logic [AddrWidth-1:0] wr_cnt_q, wr_cnt_d;
    logic                 frame_done_q, frame_done_d;
    logic [credit_w-1:0]  fifo_count, inflight;
    logic                 push, pop, last_pop, fifo_full, fifo_empty;
    output_skid_fifo #(.DataWidth(DataWidth), .Depth(FifoDepth)) u_fifo (
        .clk   (clk),
        .aclr  (aclr),
        .push  (push),
        .pop   (pop),
        .din   (pipe_data),
        .dout  (wr_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );
    // Words still travelling through the pipeline each hold a reserved FIFO slot
    always_comb begin
        inflight = '0;
        for (int i = 0; i < Stages; i++) inflight = inflight + credit_w'(vld_q[i]);
    end
    assign push        = vld_q[Stages-1];
    assign wr_valid    = !fifo_empty;
    assign pop         = wr_valid & wr_ready;
    assign last_pop    = pop & (wr_cnt_q == AddrWidth'(frame_pix - 1));
    assign credits     = credit_w'(FifoDepth) - fifo_count - inflight;
    assign issue_grant = (state_q == RUN) & issue_req & (credits != '0) & (issue_cnt_q < issue_w'(frame_pix));
    assign wr_addr     = wr_cnt_q;
    assign busy        = state_q == RUN;
    assign frame_done  = frame_done_q;
    // Next-state: frame sequencing, valid chain shift and raster counters
    always_comb begin
        state_d      = (state_q == IDLE) ? (start ? RUN : IDLE) : (last_pop ? IDLE : RUN);
        vld_d        = Stages'({vld_q, issue_grant});
        issue_cnt_d  = last_pop ? '0 : issue_cnt_q + issue_w'(issue_grant);
        wr_cnt_d     = !pop ? wr_cnt_q : (last_pop ? '0 : wr_cnt_q + 1'b1);
        frame_done_d = last_pop & (state_q == RUN);
    end
    // Control registers, all cleared by aclr
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q      <= IDLE;
            vld_q        <= '0;
            issue_cnt_q  <= '0;
            wr_cnt_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vld_q        <= vld_d;
            issue_cnt_q  <= issue_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end
    // Credits reserve a slot per grant, so the FIFO can never be pushed while full
    assert property (@(posedge clk) disable iff (aclr) !(fifo_full && push));
endmodule

// File: tb/tb_output_writeback_ctrl.sv
// tb_output_writeback_ctrl: directed and table-driven checks of the output writeback controller
module tb_output_writeback_ctrl;
    localparam int DW = 32, ST = 5, FD = 8, AW = 8, NPIX = 256;
    logic clk = 1'b0, aclr = 1'b1, start = 1'b0, issue_req = 1'b0, wr_ready = 1'b0;
    logic [DW-1:0] pipe_data, wr_data;
    logic          issue_grant, wr_valid, busy, frame_done;
    logic [AW-1:0] wr_addr;
    logic [3:0]    credits;

    output_writeback_ctrl #(.DataWidth(DW), .Stages(ST), .FifoDepth(FD), .OutCols(16), .OutRows(16), .AddrWidth(AW)) dut (
        .clk(clk), .aclr(aclr), .start(start), .issue_req(issue_req), .issue_grant(issue_grant),
        .pipe_data(pipe_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .wr_addr(wr_addr), .credits(credits), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word(input int unsigned n);
        return 32'hC0DE_0000 ^ (n * 32'h9E37_79B9);
    endfunction

    // Model of the external fixed-latency output pipeline feeding pipe_data
    logic [DW-1:0] pipe [ST];
    int unsigned   gcnt;
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < ST; i++) pipe[i] <= '0;
            gcnt <= 0;
        end else begin
            pipe[0] <= issue_grant ? word(gcnt) : '0;
            for (int i = 1; i < ST; i++) pipe[i] <= pipe[i-1];
            if (issue_grant) gcnt <= gcnt + 1;
        end
    end
    assign pipe_data = pipe[ST-1];

    int checks = 0, errors = 0, grants = 0, pops = 0, dones = 0, exp_addr = 0;
    logic [DW-1:0] exp_q [$];

    typedef struct { int g; int v; int a; int cr; int b; } vec_t;
    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic observe();
        if (issue_grant) begin
            exp_q.push_back(word(gcnt));
            grants++;
        end
        if (wr_valid && wr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_order: write at addr %0d with no outstanding grant", wr_addr);
            end else chk("wr_data", wr_data, exp_q.pop_front());
            chk("wr_addr", wr_addr, exp_addr);
            exp_addr = (exp_addr + 1) % NPIX;
            pops++;
        end
        if (frame_done) begin
            dones++;
            chk("busy_at_done", busy, 0);
        end
    endtask

    task automatic cyc(input logic st, input logic rq, input logic rd);
        start = st; issue_req = rq; wr_ready = rd;
        #1;
        observe();
        @(negedge clk);
    endtask

    task automatic end_chk(input string nm);
        chk({nm, "_done_once"}, dones, 1);
        chk({nm, "_grants"}, grants, NPIX);
        chk({nm, "_pops"}, pops, NPIX);
        chk({nm, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic run_frame(input string nm, input bit rnd, input int bound);
        int n = 0;
        grants = 0; pops = 0; dones = 0;
        cyc(1'b1, rnd ? 1'($urandom_range(0, 1)) : 1'b1, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        while (dones == 0 && n < bound) begin
            cyc(1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        end_chk(nm);
    endtask

    initial begin
        int n, done_cyc;
        tbl[0]  = '{0, 0, 0, 8, 0};
        tbl[1]  = '{1, 0, 0, 8, 1};
        tbl[2]  = '{1, 0, 0, 7, 1};
        tbl[3]  = '{1, 0, 0, 6, 1};
        tbl[4]  = '{1, 0, 0, 5, 1};
        tbl[5]  = '{1, 0, 0, 4, 1};
        tbl[6]  = '{1, 0, 0, 3, 1};
        tbl[7]  = '{1, 1, 0, 2, 1};
        tbl[8]  = '{1, 1, 1, 2, 1};
        tbl[9]  = '{1, 1, 2, 2, 1};
        tbl[10] = '{1, 1, 3, 2, 1};

        repeat (2) @(negedge clk);
        issue_req = 1'b1;
        #1;
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_credits", credits, FD);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_grant", issue_grant, 0);
        aclr = 1'b0;
        @(negedge clk);

        // Latency and credit profile from start, then the whole frame
        grants = 0; pops = 0; dones = 0; exp_addr = 0;
        for (int c = 0; c < 11; c++) begin
            start = (c == 0); issue_req = 1'b1; wr_ready = 1'b1;
            #1;
            chk($sformatf("t%0d_grant", c), issue_grant, tbl[c].g);
            chk($sformatf("t%0d_wr_valid", c), wr_valid, tbl[c].v);
            chk($sformatf("t%0d_wr_addr", c), wr_addr, tbl[c].a);
            chk($sformatf("t%0d_credits", c), credits, tbl[c].cr);
            chk($sformatf("t%0d_busy", c), busy, tbl[c].b);
            observe();
            @(negedge clk);
        end
        n = 11; done_cyc = -1;
        while (dones == 0 && n < 400) begin
            cyc(1'b0, 1'b1, 1'b1);
            if (dones != 0) done_cyc = n;
            n++;
        end
        chk("full_done_cycle", done_cyc, 263);
        repeat (3) cyc(1'b0, 1'b1, 1'b1);
        end_chk("full");
        #1;
        chk("full_addr_wrap", wr_addr, 0);
        @(negedge clk);

        // Output buffer stalled for the whole frame: only FifoDepth grants fit
        grants = 0; pops = 0; dones = 0;
        cyc(1'b1, 1'b1, 1'b0);
        repeat (29) cyc(1'b0, 1'b1, 1'b0);
        chk("stall_grants", grants, FD);
        #1;
        chk("stall_credits", credits, 0);
        chk("stall_wr_valid", wr_valid, 1);
        chk("stall_wr_addr", wr_addr, 0);
        chk("stall_wr_data", wr_data, exp_q[0]);
        chk("stall_no_grant", issue_grant, 0);
        @(negedge clk);
        n = 0;
        while (dones == 0 && n < 800) begin
            cyc(1'b0, 1'b1, 1'b1);
            n++;
        end
        repeat (3) cyc(1'b0, 1'b1, 1'b1);
        end_chk("stall");

        run_frame("random", 1'b1, 3000);

        // Asynchronous clear in the middle of a frame
        grants = 0; pops = 0; dones = 0; n = 0;
        cyc(1'b1, 1'b1, 1'b1);
        while (pops < 37 && n < 200) begin
            cyc(1'b0, 1'b1, 1'b1);
            n++;
        end
        chk("aclr_pops_before", pops, 37);
        aclr = 1'b1;
        #1;
        chk("aclr_wr_valid", wr_valid, 0);
        chk("aclr_wr_addr", wr_addr, 0);
        chk("aclr_credits", credits, FD);
        chk("aclr_busy", busy, 0);
        chk("aclr_frame_done", frame_done, 0);
        chk("aclr_grant", issue_grant, 0);
        @(negedge clk);
        aclr = 1'b0;
        exp_q.delete();
        exp_addr = 0;
        @(negedge clk);
        run_frame("after_aclr", 1'b0, 600);

        // start while busy is ignored; start alongside frame_done begins a new frame
        grants = 0; pops = 0; dones = 0;
        cyc(1'b1, 1'b1, 1'b1);
        n = 1;
        repeat (20) begin cyc(1'b0, 1'b1, 1'b1); n++; end
        cyc(1'b1, 1'b1, 1'b1);
        n++;
        while (!frame_done && n < 400) begin
            cyc(1'b0, 1'b1, 1'b1);
            n++;
        end
        chk("busy_start_done_cycle", n, 263);
        cyc(1'b1, 1'b1, 1'b1);
        end_chk("busy_start");
        grants = 0; pops = 0; dones = 0;
        #1;
        chk("restart_busy", busy, 1);
        chk("restart_grant", issue_grant, 1);
        n = 0;
        while (dones == 0 && n < 600) begin
            cyc(1'b0, 1'b1, 1'b1);
            n++;
        end
        repeat (3) cyc(1'b0, 1'b1, 1'b1);
        end_chk("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
